regfile_arbiter: RTL and testbench

Sequencer and two-way arbiter for the single write port and single asynchronous read port of the 32×32 dual-port register file. After reset it clears every entry to zero, then shares both ports between the core requester (A) and the debug/loader requester (B) with round-robin fairness, one transaction per cycle. It sits directly between the requesters and the register file's `di/waddr/we/raddr/do` pins.

---
 rtl/regfile_arbiter_if.sv | 34 +++
 rtl/regfile_arbiter.sv | 119 +++++++++++
 tb/tb_regfile_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_arbiter_if.sv
// Requester-side bus of the register-file arbiter: two request/grant channels
// (A = core, B = debug/loader) plus the shared read-return path.
interface regfile_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;

    logic [DATA_W-1:0] rdata;
    logic              a_rvalid;
    logic              b_rvalid;

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        input  a_gnt, b_gnt, rdata, a_rvalid, b_rvalid
    );

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        output a_gnt, b_gnt, rdata, a_rvalid, b_rvalid
    );
endinterface

// File: rtl/regfile_arbiter.sv
// Clears the register file after reset, then shares its single write port and
// single asynchronous read port between requesters A and B, round-robin.
module regfile_arbiter #(
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 32,
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter bit ZERO_REG0      = 1'b1
) (
    input  logic              clk,
    input  logic              resetn,
    regfile_arbiter_if.slave  bus,
    output logic              init_done,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_di,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_do
);
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic       LAST_A   = 1'b0;
    localparam logic       LAST_B   = 1'b1;
    localparam logic [ADDR_W-1:0] CLR_LAST = {ADDR_W{1'b1}};

    logic [0:0]        state_reg;
    logic [ADDR_W-1:0] clr_cnt_reg;
    logic              last_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              a_rvalid_reg;
    logic              b_rvalid_reg;

    logic              in_run;
    logic              in_clear;
    logic              grant_a;
    logic              grant_b;

    // Per-requester view so the write-suppression rule is written once.
    logic [ADDR_W-1:0] req_addr [2];
    logic              wr_en    [2];

    assign req_addr[0] = bus.a_addr;
    assign req_addr[1] = bus.b_addr;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_wr_en
            if (ZERO_REG0) begin : g_zero
                assign wr_en[gi] = (req_addr[gi] != '0);
            end else begin : g_plain
                assign wr_en[gi] = 1'b1;
            end
        end
    endgenerate

    assign in_run   = resetn && (state_reg == ST_RUN);
    assign in_clear = resetn && (state_reg == ST_CLEAR);

    // A wins a tie only when B was the most recent winner.
    assign grant_a = in_run && bus.a_req && (!bus.b_req || (last_reg == LAST_B));
    assign grant_b = in_run && bus.b_req && !grant_a;

    assign bus.a_gnt    = grant_a;
    assign bus.b_gnt    = grant_b;
    assign bus.rdata    = rdata_reg;
    assign bus.a_rvalid = a_rvalid_reg;
    assign bus.b_rvalid = b_rvalid_reg;
    assign init_done    = in_run;

    // Idle read address follows A so the async read path stays deterministic.
    assign rf_raddr = (grant_b && !bus.b_we) ? bus.b_addr : bus.a_addr;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_di    = '0;
        if (in_clear) begin
            rf_we    = 1'b1;
            rf_waddr = clr_cnt_reg;
        end else if (grant_a) begin
            rf_we    = bus.a_we && wr_en[0];
            rf_waddr = bus.a_addr;
            rf_di    = bus.a_wdata;
        end else if (grant_b) begin
            rf_we    = bus.b_we && wr_en[1];
            rf_waddr = bus.b_addr;
            rf_di    = bus.b_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg    <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_cnt_reg  <= '0;
            last_reg     <= LAST_B;
            rdata_reg    <= '0;
            a_rvalid_reg <= 1'b0;
            b_rvalid_reg <= 1'b0;
        end else begin
            a_rvalid_reg <= grant_a && !bus.a_we;
            b_rvalid_reg <= grant_b && !bus.b_we;
            if (state_reg == ST_CLEAR) begin
                // Counter parks at the last address; it never starts a second pass.
                if (clr_cnt_reg == CLR_LAST) begin
                    state_reg <= ST_RUN;
                end else begin
                    clr_cnt_reg <= clr_cnt_reg + 1'b1;
                end
            end else begin
                if (grant_a) begin
                    last_reg <= LAST_A;
                end else if (grant_b) begin
                    last_reg <= LAST_B;
                end
                if ((grant_a && !bus.a_we) || (grant_b && !bus.b_we)) begin
                    rdata_reg <= rf_do;
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural 32x32 register file.
module tb_regfile_arbiter;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              resetn;
    logic              init_done;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_di;
    logic [ADDR_W-1:0] rf_raddr;
    logic [DATA_W-1:0] rf_do;
    logic              preload;
    logic [DATA_W-1:0] mem [32];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    regfile_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLEAR_ON_RESET(1'b1), .ZERO_REG0(1'b1)
    ) dut (
        .clk(clk), .resetn(resetn), .bus(bus), .init_done(init_done),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_di(rf_di),
        .rf_raddr(rf_raddr), .rf_do(rf_do)
    );

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hFFFF_FFFF;
        end else if (rf_we) begin
            mem[rf_waddr] <= rf_di;
        end
    end
    assign rf_do = mem[rf_raddr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_grants(input string tag, input logic ea, input logic eb);
        chk({tag, ".a_gnt"}, 32'(bus.a_gnt), 32'(ea));
        chk({tag, ".b_gnt"}, 32'(bus.b_gnt), 32'(eb));
    endtask

    task automatic clear_pass(input string pfx, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk($sformatf("%s.we%0d", pfx, k), 32'(rf_we), 32'd1);
            chk($sformatf("%s.waddr%0d", pfx, k), 32'(rf_waddr), 32'(k));
            chk($sformatf("%s.di%0d", pfx, k), rf_di, 32'd0);
            chk_grants($sformatf("%s.c%0d", pfx, k), 1'b0, 1'b0);
            chk($sformatf("%s.done%0d", pfx, k), 32'(init_done), 32'd0);
            chk($sformatf("%s.rv%0d", pfx, k), 32'({bus.a_rvalid, bus.b_rvalid}), 32'd0);
            step();
        end
    endtask

    initial begin
        int nonzero;
        resetn = 1'b0;
        preload = 1'b1;
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
        step();
        @(negedge clk);
        chk("rst.rf_we", 32'(rf_we), 32'd0);
        chk_grants("rst", 1'b0, 1'b0);
        chk("rst.init_done", 32'(init_done), 32'd0);
        chk("rst.rdata", bus.rdata, 32'd0);
        chk("rst.rvalid", 32'({bus.a_rvalid, bus.b_rvalid}), 32'd0);
        step();
        resetn = 1'b1;
        preload = 1'b0;

        // Initial clear over a preloaded file.
        clear_pass("clr1", 32);
        @(negedge clk);
        chk("clr1.init_done", 32'(init_done), 32'd1);
        chk("clr1.idle_we", 32'(rf_we), 32'd0);
        nonzero = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== 32'd0) nonzero++;
        chk("clr1.nonzero_entries", 32'(nonzero), 32'd0);
        step();

        // A writes r5, then reads it back.
        bus.a_req = 1; bus.a_we = 1; bus.a_addr = 5'd5; bus.a_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk_grants("aw5", 1'b1, 1'b0);
        chk("aw5.we", 32'(rf_we), 32'd1);
        chk("aw5.waddr", 32'(rf_waddr), 32'd5);
        chk("aw5.di", rf_di, 32'hDEAD_BEEF);
        step();
        bus.a_we = 0;
        @(negedge clk);
        chk_grants("ar5", 1'b1, 1'b0);
        chk("ar5.raddr", 32'(rf_raddr), 32'd5);
        chk("ar5.we", 32'(rf_we), 32'd0);
        chk("ar5.rv_early", 32'(bus.a_rvalid), 32'd0);
        step();
        bus.a_req = 0;
        @(negedge clk);
        chk("ar5.a_rvalid", 32'(bus.a_rvalid), 32'd1);
        chk("ar5.b_rvalid", 32'(bus.b_rvalid), 32'd0);
        chk("ar5.rdata", bus.rdata, 32'hDEAD_BEEF);
        step();
        @(negedge clk);
        chk("ar5.rv_pulse", 32'(bus.a_rvalid), 32'd0);
        step();

        // B reads r5 (also makes B the most recent winner).
        bus.b_req = 1; bus.b_we = 0; bus.b_addr = 5'd5;
        @(negedge clk);
        chk_grants("br5", 1'b0, 1'b1);
        chk("br5.raddr", 32'(rf_raddr), 32'd5);
        step();
        bus.b_req = 0;
        @(negedge clk);
        chk("br5.b_rvalid", 32'(bus.b_rvalid), 32'd1);
        chk("br5.a_rvalid", 32'(bus.a_rvalid), 32'd0);
        chk("br5.rdata", bus.rdata, 32'hDEAD_BEEF);
        step();

        // Contention: both write continuously, grants alternate A,B,A,B.
        bus.a_req = 1; bus.a_we = 1; bus.a_addr = 5'd1; bus.a_wdata = 32'h1111_1111;
        bus.b_req = 1; bus.b_we = 1; bus.b_addr = 5'd2; bus.b_wdata = 32'h2222_2222;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_grants($sformatf("rr%0d", i), (i % 2) == 0, (i % 2) == 1);
            chk($sformatf("rr%0d.waddr", i), 32'(rf_waddr), (i % 2) == 0 ? 32'd1 : 32'd2);
            step();
        end
        bus.a_req = 0; bus.b_req = 0;

        // Write to r0 is granted but suppressed; reads of r0 and r1 follow.
        bus.b_req = 1; bus.b_we = 1; bus.b_addr = 5'd0; bus.b_wdata = 32'h1234_5678;
        @(negedge clk);
        chk_grants("bw0", 1'b0, 1'b1);
        chk("bw0.we", 32'(rf_we), 32'd0);
        step();
        bus.b_we = 0;
        @(negedge clk);
        chk_grants("br0", 1'b0, 1'b1);
        step();
        bus.b_req = 0;
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 5'd1;
        @(negedge clk);
        chk_grants("ar1", 1'b1, 1'b0);
        chk("br0.b_rvalid", 32'(bus.b_rvalid), 32'd1);
        chk("br0.rdata", bus.rdata, 32'd0);
        step();
        bus.a_req = 0;
        @(negedge clk);
        chk("ar1.a_rvalid", 32'(bus.a_rvalid), 32'd1);
        chk("ar1.rdata", bus.rdata, 32'h1111_1111);
        step();

        // Reset with requests held, restart mid-clear, first grant in cycle 32.
        resetn = 0;
        bus.a_req = 1; bus.a_we = 1; bus.a_addr = 5'd3; bus.a_wdata = 32'hAAAA_AAAA;
        bus.b_req = 1; bus.b_we = 1; bus.b_addr = 5'd4; bus.b_wdata = 32'hBBBB_BBBB;
        @(negedge clk);
        chk_grants("rst2", 1'b0, 1'b0);
        chk("rst2.we", 32'(rf_we), 32'd0);
        chk("rst2.init_done", 32'(init_done), 32'd0);
        step();
        resetn = 1;
        clear_pass("clr2", 10);
        resetn = 0;
        @(negedge clk);
        chk_grants("rst3", 1'b0, 1'b0);
        chk("rst3.we", 32'(rf_we), 32'd0);
        step();
        resetn = 1;
        clear_pass("clr3", 32);
        @(negedge clk);
        chk("clr3.init_done", 32'(init_done), 32'd1);
        chk_grants("first", 1'b1, 1'b0);
        chk("first.waddr", 32'(rf_waddr), 32'd3);
        chk("first.we", 32'(rf_we), 32'd1);
        step();
        bus.a_req = 0;
        @(negedge clk);
        chk_grants("second", 1'b0, 1'b1);
        chk("second.waddr", 32'(rf_waddr), 32'd4);
        step();
        bus.b_req = 0;
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 5'd5;
        @(negedge clk);
        chk_grants("ar5b", 1'b1, 1'b0);
        step();
        bus.a_req = 0;
        @(negedge clk);
        chk("ar5b.a_rvalid", 32'(bus.a_rvalid), 32'd1);
        chk("ar5b.rdata", bus.rdata, 32'd0);
        chk("mem3", mem[3], 32'hAAAA_AAAA);
        chk("mem4", mem[4], 32'hBBBB_BBBB);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
